// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the sram-like req/addr_ok/data_ok bus.
// Handshake: a request transfers on a cycle where req & addr_ok are both high
// (at most one per cycle). addr_ok is a function of registered state and stall
// only, never of req. Every accepted request, read or write, returns exactly
// one data_ok pulse LATENCY cycles after its accept cycle, strictly in order.
// rdata is meaningful only on the data_ok of a read and is 0 otherwise.
module sram_like_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [3:0] TIMER_INIT = 4'(LATENCY - 1);

  // Response queue: one slot per outstanding request.
  logic          q_valid [QDEPTH];
  logic          q_wr    [QDEPTH];
  logic [31:0]   q_data  [QDEPTH];
  logic [3:0]    q_timer [QDEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Backing store; deliberately left out of reset so contents survive it.
  logic [31:0]   mem [(1 << MEM_AW)];

  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              retire;
  logic [31:0]       mem_rd;

  // size is informational and the address bits outside the word index alias.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign idx     = addr[MEM_AW+1:2];
  assign mem_rd  = mem[idx];
  assign addr_ok = ~reset & ~stall & (count != CW'(QDEPTH));
  assign accept  = req & addr_ok;
  // The oldest entry always expires first, so only the head can retire.
  assign retire  = q_valid[head] & (q_timer[head] == 4'd0);
  assign data_ok = ~reset & retire;
  assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

  // Queue slots: load at tail on accept, free at head on retire, else count down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_wr[i]    <= 1'b0;
        q_data[i]  <= 32'h0;
        q_timer[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (accept && (tail == PW'(i))) begin
          q_valid[i] <= 1'b1;
          q_wr[i]    <= wr;
          q_data[i]  <= wr ? 32'h0 : mem_rd;
          q_timer[i] <= TIMER_INIT;
        end else if (retire && (head == PW'(i))) begin
          q_valid[i] <= 1'b0;
        end else if (q_valid[i] && (q_timer[i] != 4'd0)) begin
          q_timer[i] <= q_timer[i] - 4'd1;
        end
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (retire) head <= head + PW'(1);
      case ({accept, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte-strobed write into the backing store on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus random traffic,
// checked every cycle against a queue-of-due-cycles reference model.
module tb_sram_like_responder;

  localparam int MEM_AW  = 12;
  localparam int LATENCY = 4;
  localparam int QDEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sram_like_responder #(.MEM_AW(MEM_AW), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .stall(stall),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: pending responses with the cycle they are due, plus memory.
  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  pend_t       exp_q[$];
  logic [31:0] mm [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_get(input int i);
    return mm.exists(i) ? mm[i] : 32'h0;
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, input logic st);
    logic        exp_ok;
    logic        exp_dv;
    logic [31:0] exp_rd;
    logic [31:0] v;
    int          i;
    req = r; wr = w; wstrb = s; addr = a; wdata = d; stall = st; size = 2'd2;
    @(negedge clk);
    exp_ok = !st && (exp_q.size() < QDEPTH);
    exp_dv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    exp_rd = exp_dv ? exp_q[0].data : 32'h0;
    check("addr_ok", {31'h0, addr_ok}, {31'h0, exp_ok});
    check("data_ok", {31'h0, data_ok}, {31'h0, exp_dv});
    check("rdata", rdata, exp_rd);
    if (exp_dv) void'(exp_q.pop_front());
    if (r && exp_ok) begin
      i = int'(a[MEM_AW+1:2]);
      exp_q.push_back('{due: cyc + LATENCY, data: w ? 32'h0 : mem_get(i)});
      if (w) begin
        v = mem_get(i);
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mm[i] = v;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset pulse of one cycle, asserted away from the clock edge.
  task automatic pulse_reset();
    reset = 1'b1; req = 1'b1; stall = 1'b0;
    #1;
    check("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
    check("rst_data_ok", {31'h0, data_ok}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0; req = 1'b0;
    cyc++;
  endtask

  initial begin
    logic [31:0] a;
    // Initial reset and reset-state checks.
    repeat (2) @(posedge clk);
    #1;
    check("init_addr_ok", {31'h0, addr_ok}, 32'h0);
    check("init_data_ok", {31'h0, data_ok}, 32'h0);
    check("init_rdata", rdata, 32'h0);
    reset = 1'b0;

    // Give words 0..31 known contents.
    for (int w = 0; w < 32; w++) step(1'b1, 1'b1, 4'hF, w * 4, $urandom, 1'b0);
    idle(LATENCY + 1);

    // Write then read back-to-back, same word.
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(LATENCY + 1);

    // Byte strobe merge and address aliasing.
    step(1'b1, 1'b1, 4'hF, 32'h40, 32'h11223344, 1'b0);
    step(1'b1, 1'b1, 4'b0010, 32'h40, 32'h0000AB00, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h4040, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 32'h44, 32'hFFFFFFFF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h47, 32'h0, 1'b0);
    idle(LATENCY + 1);

    // Back-pressure: req held high fills the queue.
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 4'h0, (k % 8) * 4, 32'h0, 1'b0);
    idle(LATENCY + 1);

    // Stall blocks acceptance, then releases.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(LATENCY + 1);

    // Reset with reads outstanding; memory must survive.
    step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    pulse_reset();
    idle(1);
    step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    idle(LATENCY + 1);

    // Random traffic over aliased addresses, with one reset in the middle.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) pulse_reset();
      a = ($urandom << (MEM_AW + 2)) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           a, $urandom, $urandom_range(0, 7) == 0);
    end
    idle(LATENCY + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
